// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes with
// optional extra redirect cycles, and whole-pipe freezes while data memory is busy.
module hazard_ctrl #(
  parameter int EXTRA_FLUSH = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             busy_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0]       FCNT_INIT = 4'(EXTRA_FLUSH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic             stall_inc, flush_inc, freeze_inc;
  logic             load_use;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    freeze_inc   = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (dmem_busy) begin
      // Freeze holds EX, so a branch seen here is re-presented after busy drops.
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      freeze_inc = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      if (EXTRA_FLUSH == 0) begin
        state_d = ST_RUN;
        fcnt_d  = 4'd0;
      end else begin
        state_d = ST_FLUSH;
        fcnt_d  = FCNT_INIT;
      end
    end else if (state_q == ST_FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      if (fcnt_q <= 4'd1) begin
        state_d = ST_RUN;
        fcnt_d  = 4'd0;
      end else begin
        fcnt_d = fcnt_q - 4'd1;
      end
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
    end

    stall_cnt_d  = (stall_inc  && (stall_cnt_q  != CNT_MAX)) ? stall_cnt_q  + 1'b1 : stall_cnt_q;
    flush_cnt_d  = (flush_inc  && (flush_cnt_q  != CNT_MAX)) ? flush_cnt_q  + 1'b1 : flush_cnt_q;
    freeze_cnt_d = (freeze_inc && (freeze_cnt_q != CNT_MAX)) ? freeze_cnt_q + 1'b1 : freeze_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      fcnt_q       <= 4'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign busy_state = (state_q == ST_FLUSH);
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule
